// File: rtl/proc_pkg.sv
// Shared definitions for the proc_core teaching CPU: opcodes, instruction
// field positions, bus widths and the hex-to-7-segment table.
// The table is active-high {g,f,e,d,c,b,a}; polarity for the board is
// applied in seg7_dec (macro PROC_SEG_ACTIVE_LOW_EN).
package proc_pkg;

    localparam int unsigned INST_W = 8;
    localparam int unsigned PC_W   = 8;
    localparam int unsigned SEG_W  = 7;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned REG_N  = 4;
    localparam int unsigned REG_AW = 2;

    // Opcodes in inst[7:6]
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_LW  = 2'b01;
    localparam logic [1:0] OP_SW  = 2'b10;
    localparam logic [1:0] OP_J   = 2'b11;

    // Field slice positions
    localparam int unsigned OP_HI  = 7;
    localparam int unsigned OP_LO  = 6;
    localparam int unsigned RS_HI  = 5;
    localparam int unsigned RS_LO  = 4;
    localparam int unsigned RT_HI  = 3;
    localparam int unsigned RT_LO  = 2;
    localparam int unsigned RD_HI  = 1;
    localparam int unsigned RD_LO  = 0;
    localparam int unsigned OFF_HI = 5;
    localparam int unsigned OFF_W  = OFF_HI + 1;
    localparam int unsigned IMM_W  = RD_HI + 1;

    // Instruction viewed as packed fields; imm2 overlays rd, off6 overlays rs/rt/rd
    typedef struct packed {
        logic [OP_HI-OP_LO:0] op;
        logic [RS_HI-RS_LO:0] rs;
        logic [RT_HI-RT_LO:0] rt;
        logic [RD_HI-RD_LO:0] rd;
    } inst_t;

    // Active-high hex digit patterns, bit order {g,f,e,d,c,b,a}
    function automatic logic [SEG_W-1:0] hex_to_seg(input logic [NIB_W-1:0] h);
        logic [SEG_W-1:0] s;
        s = 7'h00;
        case (h)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            4'hF: s = 7'h71;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/proc_if.sv
// Core-to-board bus: IMEM fetch (pc out, inst back) and the two
// 7-segment digit outputs.
//   master (core): drives pc, num1, num2; receives inst
//   slave  (board/IMEM): drives inst; receives pc, num1, num2
interface proc_if;
    import proc_pkg::*;

    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
    logic [SEG_W-1:0]  num1;
    logic [SEG_W-1:0]  num2;

    modport master (input inst, output pc, output num1, output num2);
    modport slave  (output inst, input pc, input num1, input num2);

endinterface

// File: rtl/seg7_dec.sv
// One hex digit to 7-segment pattern {g,f,e,d,c,b,a}.
//   hex in  4  nibble to show
//   seg out 7  segment drive (combinational)
// Macro PROC_SEG_ACTIVE_LOW_EN: defined -> inverted outputs for
// common-anode displays; undefined -> active-high.
module seg7_dec
    import proc_pkg::*;
(
    input  logic [NIB_W-1:0] hex,
    output logic [SEG_W-1:0] seg
);

`ifdef PROC_SEG_ACTIVE_LOW_EN
    assign seg = ~hex_to_seg(hex);
`else
    assign seg = hex_to_seg(hex);
`endif

endmodule

// File: rtl/proc_core.sv
// Single-cycle 8-bit teaching CPU: ADD / LW / SW / J over 4 GPRs and an
// internal data memory, last write-back value shown on two hex digits.
//   clk       in   rising-edge clock
//   clr       in   asynchronous active-low reset
//   bus.inst  in   instruction from external combinational IMEM at bus.pc
//   bus.pc    out  program counter (registered)
//   bus.num1  out  7-seg of display high nibble (combinational from disp)
//   bus.num2  out  7-seg of display low nibble
// Macro PROC_SEG_ACTIVE_LOW_EN selects inverted segment polarity.
module proc_core
    import proc_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned DMEM_DEPTH = 32
)(
    input  logic  clk,
    input  logic  clr,
    proc_if.master bus
);

    localparam int unsigned AW = $clog2(DMEM_DEPTH);

    logic [DATA_W-1:0] regs [REG_N];
    logic [DATA_W-1:0] dmem [DMEM_DEPTH];
    logic [PC_W-1:0]   pc_q;
    logic [DATA_W-1:0] disp_q;

    inst_t             ir;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic [DATA_W-1:0] imm2;
    logic [PC_W-1:0]   off6;
    logic [AW-1:0]     addr;
    logic [DATA_W-1:0] ld_val;

    // Decode results
    logic              reg_we;
    logic [REG_AW-1:0] reg_wa;
    logic [DATA_W-1:0] reg_wd;
    logic              mem_we;
    logic              disp_we;
    logic [PC_W-1:0]   pc_nxt;

    // Operand fetch and effective address (8-bit add, then low AW bits)
    assign ir     = inst_t'(bus.inst);
    assign rs_val = regs[ir.rs];
    assign rt_val = regs[ir.rt];
    assign imm2   = {{(DATA_W-IMM_W){ir.rd[IMM_W-1]}}, ir.rd};
    assign off6   = {{(PC_W-OFF_W){bus.inst[OFF_HI]}}, bus.inst[OFF_HI:0]};
    assign addr   = AW'(rs_val + imm2);
    assign ld_val = dmem[addr];

    // Instruction decode / next-state
    always_comb begin
        reg_we  = 1'b0;
        reg_wa  = ir.rd;
        reg_wd  = rs_val + rt_val;
        mem_we  = 1'b0;
        disp_we = 1'b0;
        pc_nxt  = pc_q + PC_W'(1);
        case (ir.op)
            OP_ADD: begin
                reg_we  = 1'b1;
                disp_we = 1'b1;
            end
            OP_LW: begin
                reg_we  = 1'b1;
                reg_wa  = ir.rt;
                reg_wd  = ld_val;
                disp_we = 1'b1;
            end
            OP_SW: begin
                mem_we = 1'b1;
            end
            OP_J: begin
                pc_nxt = pc_q + PC_W'(1) + off6;
            end
            default: begin
                pc_nxt = pc_q + PC_W'(1);
            end
        endcase
    end

    // pc and display register
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            pc_q   <= '0;
            disp_q <= '0;
        end else begin
            pc_q <= pc_nxt;
            if (disp_we) begin
                disp_q <= reg_wd;
            end
        end
    end

    // Register file; no hardwired zero register
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < int'(REG_N); i++) begin
                regs[i] <= '0;
            end
        end else if (reg_we) begin
            regs[reg_wa] <= reg_wd;
        end
    end

    // Data memory; reset loads the identity pattern DMEM[i] = i
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < int'(DMEM_DEPTH); i++) begin
                dmem[i] <= DATA_W'(i);
            end
        end else if (mem_we) begin
            dmem[addr] <= rt_val;
        end
    end

    assign bus.pc = pc_q;

    seg7_dec u_seg_hi (
        .hex (disp_q[DATA_W-1:NIB_W]),
        .seg (bus.num1)
    );

    seg7_dec u_seg_lo (
        .hex (disp_q[NIB_W-1:0]),
        .seg (bus.num2)
    );

endmodule

// File: tb/tb_proc_core.sv
// Directed bench for proc_core with a behavioural IMEM program.
module tb_proc_core;

    logic clk;
    logic clr;
    int   checks;
    int   errors;

    logic [7:0] imem [256];

    proc_if bus ();

    proc_core dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    // Combinational IMEM
    always_comb bus.inst = imem[bus.pc];

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Expected segment pattern for a hex digit
    function automatic logic [6:0] seg_exp(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h3F; 4'h1: s = 7'h06; 4'h2: s = 7'h5B; 4'h3: s = 7'h4F;
            4'h4: s = 7'h66; 4'h5: s = 7'h6D; 4'h6: s = 7'h7D; 4'h7: s = 7'h07;
            4'h8: s = 7'h7F; 4'h9: s = 7'h6F; 4'hA: s = 7'h77; 4'hB: s = 7'h7C;
            4'hC: s = 7'h39; 4'hD: s = 7'h5E; 4'hE: s = 7'h79; default: s = 7'h71;
        endcase
`ifdef PROC_SEG_ACTIVE_LOW_EN
        s = ~s;
`endif
        return s;
    endfunction

    task automatic chk_pc(input string tag, input logic [7:0] exp);
        checks++;
        assert (bus.pc === exp) else begin
            errors++;
            $error("FAIL %s pc observed=%h expected=%h", tag, bus.pc, exp);
        end
    endtask

    task automatic chk_disp(input string tag, input logic [7:0] val);
        logic [6:0] e1;
        logic [6:0] e2;
        e1 = seg_exp(val[7:4]);
        e2 = seg_exp(val[3:0]);
        checks++;
        assert (bus.num1 === e1) else begin
            errors++;
            $error("FAIL %s num1 observed=%h expected=%h", tag, bus.num1, e1);
        end
        checks++;
        assert (bus.num2 === e2) else begin
            errors++;
            $error("FAIL %s num2 observed=%h expected=%h", tag, bus.num2, e2);
        end
    endtask

    // Advance one rising edge, sample 1 ns later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 256; i++) imem[i] = 8'hFF;
        imem[0]  = 8'h45;  // LW  R1 <= DMEM[R0+1]          -> 01
        imem[1]  = 8'h16;  // ADD R2 <= R1+R1               -> 02
        imem[2]  = 8'h89;  // SW  DMEM[R0+1] <= R2
        imem[3]  = 8'h45;  // LW  R1 <= DMEM[1]             -> 02
        imem[4]  = 8'h4E;  // LW  R3 <= DMEM[(0-2) mod 32]  -> 1E
        imem[5]  = 8'h15;  // ADD R1 <= R1+R1               -> 04
        imem[6]  = 8'h15;  //                               -> 08
        imem[7]  = 8'h15;  //                               -> 10
        imem[8]  = 8'h15;  //                               -> 20
        imem[9]  = 8'h3F;  // ADD R3 <= R3+R3               -> 3C
        imem[10] = 8'h3F;  //                               -> 78
        imem[11] = 8'h3F;  //                               -> F0
        imem[12] = 8'h37;  // ADD R3 <= R3+R1 = F0+20       -> 10
        imem[13] = 8'hFF;  // J -1: spin at 13

        clr = 1'b0;
        #50;
        chk_pc("rst_pc", 8'h00);
        chk_disp("rst_disp", 8'h00);
        #40;  // edges at 70 and 90 with clr held low
        chk_pc("rst_hold_pc", 8'h00);
        #10 clr = 1'b1;  // release at t=100, clk falling

        step(); chk_pc("lw1_pc", 8'h01); chk_disp("lw1", 8'h01);
        step(); chk_pc("add_pc", 8'h02); chk_disp("add", 8'h02);
        step(); chk_pc("sw_pc", 8'h03);  chk_disp("sw_nodisp", 8'h02);
        step(); chk_pc("lw2_pc", 8'h04); chk_disp("lw_after_sw", 8'h02);
        step(); chk_disp("lw_negimm", 8'h1E);
        step(); chk_disp("dbl4", 8'h04);
        step(); chk_disp("dbl8", 8'h08);
        step(); chk_disp("dbl10", 8'h10);
        step(); chk_disp("dbl20", 8'h20);
        step(); chk_disp("dbl3c", 8'h3C);
        step(); chk_disp("dbl78", 8'h78);
        step(); chk_disp("dblf0", 8'hF0); chk_pc("chain_pc", 8'h0C);
        step(); chk_disp("carry", 8'h10); chk_pc("carry_pc", 8'h0D);
        step(); chk_pc("jself1", 8'h0D);
        step(); chk_pc("jself2", 8'h0D);
        step(); chk_pc("jself3", 8'h0D); chk_disp("jself_disp", 8'h10);

        // Async clear between edges while clk is high
        #4 clr = 1'b0;
        #1;
        chk_pc("async_pc", 8'h00);
        chk_disp("async_disp", 8'h00);

        imem[0]     = 8'hFE;  // J -2 from pc 0 -> FF
        imem[8'hFF] = 8'hC1;  // J +1 from FF   -> 01
        imem[1]     = 8'h45;  // LW R1 <= DMEM[1] (reset value 1)
        imem[2]     = 8'hFF;
        step(); chk_pc("clr_hold_pc", 8'h00);
        @(negedge clk) clr = 1'b1;

        step(); chk_pc("j_back_wrap", 8'hFF); chk_disp("j_nodisp", 8'h00);
        step(); chk_pc("j_fwd_wrap", 8'h01);
        step(); chk_pc("lw_rst_pc", 8'h02); chk_disp("dmem_reinit", 8'h01);
        step(); chk_pc("jself_end", 8'h02);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
